// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode.
// Buffers {pc, instr} pairs and hands them to decode over a valid/ready
// handshake. A flush on redirect empties the queue in one cycle.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h00003000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic [63:0]   head;

  // Handshake qualifiers come only from registered occupancy, so neither
  // side sees a combinational path from the other side's handshake.
  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  // Head is read straight out of storage; an empty queue shows a nop at the
  // reset PC so decode never sees stale or undefined data.
  assign head      = mem_q[rp_q];
  assign out_pc    = out_valid ? head[63:32] : PC_RESET;
  assign out_instr = out_valid ? head[31:0]  : 32'h00000000;

  // Next-state for pointers and occupancy; reset and flush both empty the queue
  // and discard any same-cycle push or pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (reset || flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    wp_q  <= wp_d;
    rp_q  <= rp_d;
    cnt_q <= cnt_d;
  end

  // Entry storage; written only on an accepted push that is not being discarded.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem_q[wp_q] <= {in_pc, in_instr};
    end
  end

endmodule
